block_memory_responder: RTL and testbench

- Backing main-memory responder on the far side of the direct-mapped data cache.
- Serves 4-word (128-bit) block refills on read misses.
- Accepts single-word write-through stores.
- Completes each transaction after a programmable latency with a one-cycle ready pulse.

---
 rtl/block_memory_responder.sv | 115 +++++++++++
 tb/tb_block_memory_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_memory_responder.sv
// Main-memory responder behind the direct-mapped data cache: 4-word block refills, single-word stores.
// Latency: request accepted at edge N, one-cycle ready pulse in the cycle after edge N+LATENCY.
// Backpressure: none; requester holds MemRead/MemWrite until ready, then drops or changes them.
module block_memory_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Word_Address,
  input  logic [31:0]       Data_In,
  output logic [127:0]      Data_Out,
  output logic              ready,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // Counter preload; the wait states spend LATENCY edges including the one leaving them.
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [127:0]      dout_q;
  logic [31:0]       mem_q [2**ADDR_W];

  logic              rd_done;
  logic              wr_done;
  logic [ADDR_W-3:0] blk;

  // The edge leaving a wait state is the edge that performs the memory access.
  assign rd_done = (state_q == RD_WAIT) && (cnt_q == 4'd0);
  assign wr_done = (state_q == WR_WAIT) && (cnt_q == 4'd0);
  assign blk     = addr_q[ADDR_W-1:2];

  assign Data_Out = dout_q;
  assign ready    = (state_q == DONE);
  assign busy     = (state_q == RD_WAIT) || (state_q == WR_WAIT);

  // Next-state logic: writes win over reads in IDLE; inputs are ignored once a request is latched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          state_d = WR_WAIT;
          addr_d  = Word_Address;
          data_d  = Data_In;
          cnt_d   = LAT_M1;
        end else if (MemRead) begin
          state_d = RD_WAIT;
          addr_d  = Word_Address;
          cnt_d   = LAT_M1;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        // Requests are not sampled here, so a held request restarts one cycle later.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and latched-request registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Word store; reset forces IDLE so an aborted write can never reach the array.
  always_ff @(posedge clk) begin
    if (wr_done) begin
      mem_q[addr_q] <= data_q;
    end
  end

  // Refill block register; low address bits are ignored so the whole aligned block is returned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= 128'd0;
    end else if (rd_done) begin
      dout_q <= {mem_q[{blk, 2'b11}], mem_q[{blk, 2'b10}],
                 mem_q[{blk, 2'b01}], mem_q[{blk, 2'b00}]};
    end
  end

endmodule

// File: tb/tb_block_memory_responder.sv
// Bench for block_memory_responder: LATENCY=4 main instance plus a LATENCY=1 instance.
// Expected completions are queued when a request is driven and compared when ready pulses.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_block_memory_responder;

  localparam int LAT  = 4;
  localparam int LAT1 = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         MemRead = 1'b0, MemWrite = 1'b0;
  logic [9:0]   Word_Address = '0;
  logic [31:0]  Data_In = '0;
  logic [127:0] Data_Out;
  logic         ready, busy;

  logic         rd1 = 1'b0, wr1 = 1'b0;
  logic [9:0]   addr1 = '0;
  logic [31:0]  din1 = '0;
  logic [127:0] dout1;
  logic         ready1, busy1;

  typedef struct {
    int           cyc;
    logic [127:0] dout;
  } exp_t;

  exp_t         exp_q[$];
  logic [31:0]  model_mem [1024];
  logic [127:0] model_dout = '0;
  int           n_cmp = 0;
  int           n_err = 0;

  block_memory_responder #(.LATENCY(LAT), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Word_Address(Word_Address), .Data_In(Data_In), .Data_Out(Data_Out),
    .ready(ready), .busy(busy)
  );

  block_memory_responder #(.LATENCY(LAT1), .ADDR_W(10)) dut1 (
    .clk(clk), .reset(reset), .MemRead(rd1), .MemWrite(wr1),
    .Word_Address(addr1), .Data_In(din1), .Data_Out(dout1),
    .ready(ready1), .busy(busy1)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] blk(input logic [9:0] a);
    logic [9:0] b;
    b = {a[9:2], 2'b00};
    return {model_mem[b + 10'd3], model_mem[b + 10'd2], model_mem[b + 10'd1], model_mem[b]};
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    MemRead = rd;
    MemWrite = wr;
    Word_Address = a;
    Data_In = d;
  endtask

  // Counts falling edges until ready; returns with the clock at the ready cycle's falling edge.
  task automatic wait_done(output int cyc, output int bcnt, output logic [127:0] dout, output bit ovl);
    cyc = 0;
    bcnt = 0;
    ovl = 1'b0;
    dout = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (busy && ready) ovl = 1'b1;
      if (ready) begin
        dout = Data_Out;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL wait_ready: no ready within 64 cycles (got none, need one)");
    cyc = -1;
  endtask

  task automatic write_word(input logic [9:0] a, input logic [31:0] d);
    int c, b;
    logic [127:0] o;
    bit v;
    drive(1'b0, 1'b1, a, d);
    wait_done(c, b, o, v);
    MemWrite = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b need 0", ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_cmp++; if (Data_Out !== 128'd0) begin n_err++; $display("FAIL reset_dout: got %h need 0", Data_Out); end
    n_cmp++; if ({ready1, busy1} !== 2'b00) begin n_err++; $display("FAIL reset1_flags: got %b need 00", {ready1, busy1}); end
    n_cmp++; if (dout1 !== 128'd0) begin n_err++; $display("FAIL reset1_dout: got %h need 0", dout1); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_single;
    int c, b;
    logic [127:0] o;
    bit v;
    exp_t e;
    exp_q.push_back('{cyc: LAT + 1, dout: model_dout});
    drive(1'b0, 1'b1, 10'h005, 32'hDEAD_BEEF);
    wait_done(c, b, o, v);
    MemWrite = 1'b0;
    model_mem[10'h005] = 32'hDEAD_BEEF;
    e = exp_q.pop_front();
    n_cmp++; if (c !== e.cyc) begin n_err++; $display("FAIL wr_latency: got %0d need %0d", c, e.cyc); end
    n_cmp++; if (b !== LAT) begin n_err++; $display("FAIL wr_busy_cycles: got %0d need %0d", b, LAT); end
    n_cmp++; if (o !== e.dout) begin n_err++; $display("FAIL wr_dout: got %h need %h", o, e.dout); end
    n_cmp++; if (v !== 1'b0) begin n_err++; $display("FAIL wr_overlap: got %b need 0", v); end
    @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL wr_pulse_width: got %b need 0", ready); end
  endtask

  task automatic test_block_read;
    int c, b;
    logic [127:0] o;
    bit v;
    exp_t e;
    write_word(10'h010, 32'h11);
    write_word(10'h011, 32'h22);
    write_word(10'h012, 32'h33);
    write_word(10'h013, 32'h44);
    exp_q.push_back('{cyc: LAT + 1, dout: blk(10'h012)});
    drive(1'b1, 1'b0, 10'h012, 32'h0);
    wait_done(c, b, o, v);
    MemRead = 1'b0;
    e = exp_q.pop_front();
    model_dout = e.dout;
    n_cmp++; if (c !== e.cyc) begin n_err++; $display("FAIL rd_latency: got %0d need %0d", c, e.cyc); end
    n_cmp++; if (o !== e.dout) begin n_err++; $display("FAIL rd_block: got %h need %h", o, e.dout); end
    n_cmp++; if (o !== 128'h00000044_00000033_00000022_00000011) begin
      n_err++; $display("FAIL rd_block_const: got %h need 00000044000000330000002200000011", o);
    end
    @(negedge clk);
    n_cmp++; if (Data_Out !== e.dout) begin n_err++; $display("FAIL rd_hold: got %h need %h", Data_Out, e.dout); end
  endtask

  task automatic test_rw_conflict;
    int c, b;
    logic [127:0] o;
    bit v;
    exp_t e;
    write_word(10'h3FC, 32'h0);
    write_word(10'h3FD, 32'h3D);
    write_word(10'h3FE, 32'h3E);
    write_word(10'h3FF, 32'h3F);
    exp_q.push_back('{cyc: LAT + 1, dout: model_dout});
    drive(1'b1, 1'b1, 10'h3FC, 32'hA5A5_A5A5);
    wait_done(c, b, o, v);
    MemWrite = 1'b0;
    model_mem[10'h3FC] = 32'hA5A5_A5A5;
    e = exp_q.pop_front();
    n_cmp++; if (c !== e.cyc) begin n_err++; $display("FAIL conflict_wr_latency: got %0d need %0d", c, e.cyc); end
    n_cmp++; if (o !== e.dout) begin n_err++; $display("FAIL conflict_wr_dout: got %h need %h", o, e.dout); end
    // Read stays pending: DONE -> IDLE, then accepted, then LATENCY more edges.
    exp_q.push_back('{cyc: LAT + 2, dout: blk(10'h3FC)});
    wait_done(c, b, o, v);
    MemRead = 1'b0;
    e = exp_q.pop_front();
    model_dout = e.dout;
    n_cmp++; if (c !== e.cyc) begin n_err++; $display("FAIL conflict_rd_latency: got %0d need %0d", c, e.cyc); end
    n_cmp++; if (o !== e.dout) begin n_err++; $display("FAIL conflict_rd_block: got %h need %h", o, e.dout); end
    n_cmp++; if (o[31:0] !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL conflict_word0: got %h need a5a5a5a5", o[31:0]); end
  endtask

  task automatic test_latch_ignore;
    int c, b;
    logic [127:0] o;
    bit v;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      write_word(10'h040 + 10'(i), 32'h4000 + 32'(i));
      write_word(10'h080 + 10'(i), 32'h8000 + 32'(i));
    end
    exp_q.push_back('{cyc: LAT + 1, dout: model_dout});
    drive(1'b0, 1'b1, 10'h040, 32'h0000_1234);
    @(negedge clk);
    Word_Address = 10'h081;
    Data_In = 32'hFFFF_FFFF;
    MemRead = 1'b1;
    wait_done(c, b, o, v);
    MemWrite = 1'b0;
    MemRead = 1'b0;
    model_mem[10'h040] = 32'h0000_1234;
    e = exp_q.pop_front();
    n_cmp++; if (c + 1 !== e.cyc) begin n_err++; $display("FAIL latch_latency: got %0d need %0d", c + 1, e.cyc); end
    n_cmp++; if (o !== e.dout) begin n_err++; $display("FAIL latch_wr_dout: got %h need %h", o, e.dout); end
    exp_q.push_back('{cyc: LAT + 1, dout: blk(10'h041)});
    drive(1'b1, 1'b0, 10'h041, 32'h0);
    wait_done(c, b, o, v);
    MemRead = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (o !== e.dout) begin n_err++; $display("FAIL latch_orig_block: got %h need %h", o, e.dout); end
    exp_q.push_back('{cyc: LAT + 1, dout: blk(10'h080)});
    drive(1'b1, 1'b0, 10'h080, 32'h0);
    wait_done(c, b, o, v);
    MemRead = 1'b0;
    e = exp_q.pop_front();
    model_dout = e.dout;
    n_cmp++; if (o !== e.dout) begin n_err++; $display("FAIL latch_new_untouched: got %h need %h", o, e.dout); end
  endtask

  task automatic test_reset_abort;
    int c, b, pulses;
    logic [127:0] o;
    bit v;
    exp_t e;
    write_word(10'h020, 32'h1);
    write_word(10'h021, 32'h2);
    write_word(10'h022, 32'h3);
    write_word(10'h023, 32'h4);
    drive(1'b0, 1'b1, 10'h020, 32'h0000_0099);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b need 1", busy); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({ready, busy} !== 2'b00) begin n_err++; $display("FAIL abort_flags: got %b need 00", {ready, busy}); end
    n_cmp++; if (Data_Out !== 128'd0) begin n_err++; $display("FAIL abort_dout: got %h need 0", Data_Out); end
    @(negedge clk);
    MemWrite = 1'b0;
    reset = 1'b0;
    model_dout = '0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort_no_ready: got %0d pulses need 0", pulses); end
    exp_q.push_back('{cyc: LAT + 1, dout: blk(10'h020)});
    drive(1'b1, 1'b0, 10'h020, 32'h0);
    wait_done(c, b, o, v);
    MemRead = 1'b0;
    e = exp_q.pop_front();
    model_dout = e.dout;
    n_cmp++; if (o !== e.dout) begin n_err++; $display("FAIL abort_not_committed: got %h need %h", o, e.dout); end
    n_cmp++; if (o[31:0] !== 32'h1) begin n_err++; $display("FAIL abort_word0: got %h need 00000001", o[31:0]); end
  endtask

  task automatic test_back_to_back;
    int pulse_at[$];
    bit ovl;
    ovl = 1'b0;
    @(negedge clk);
    rd1 = 1'b1;
    addr1 = 10'h010;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ready1 && busy1) ovl = 1'b1;
      if (ready1) pulse_at.push_back(i);
    end
    rd1 = 1'b0;
    n_cmp++; if (pulse_at.size() !== 3) begin
      n_err++; $display("FAIL b2b_count: got %0d pulses need 3", pulse_at.size());
    end else begin
      n_cmp++; if (pulse_at[0] !== LAT1 + 1) begin n_err++; $display("FAIL b2b_first: got %0d need %0d", pulse_at[0], LAT1 + 1); end
      n_cmp++; if (pulse_at[1] - pulse_at[0] !== 3) begin n_err++; $display("FAIL b2b_gap1: got %0d need 3", pulse_at[1] - pulse_at[0]); end
      n_cmp++; if (pulse_at[2] - pulse_at[1] !== 3) begin n_err++; $display("FAIL b2b_gap2: got %0d need 3", pulse_at[2] - pulse_at[1]); end
    end
    n_cmp++; if (ovl !== 1'b0) begin n_err++; $display("FAIL b2b_overlap: got %b need 0", ovl); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_block_read();
    test_rw_conflict();
    test_latch_ignore();
    test_reset_abort();
    test_back_to_back();
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left need 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
